approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width; legal values 4, 8, 12 and 16.
REQ-002 The block SHALL have parameter TRUNC, default 4: number of low result columns dropped in approximate mode; legal range 0..WIDTH.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  input transaction present.
REQ-007 in_ready  out  1  block accepts an input this cycle.
REQ-008 in_a, in_b  in  WIDTH  unsigned operands.
REQ-009 in_approx  in  1  1 = approximate product, 0 = exact product.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_p  out  2*WIDTH  product.
REQ-013 out_approx  out  1  echo of in_approx for this result.

Function
REQ-014 Exact product SHALL be the unsigned product A*B.
REQ-015 Approximate product SHALL be the sum of partial products a[i]&b[j] weighted 2^(i+j), over i+j >= TRUNC only; no compensation term; TRUNC=0 SHALL equal exact.
REQ-016 The pipeline SHALL have 3 register stages: S1 operand/mode capture; S2 4x4 tile products (WIDTH/4 squared tiles, column mask applied); S3 tile sum to out_p.
REQ-017 Latency SHALL be exactly 3 cycles from an input handshake to out_valid with no stall.
REQ-018 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-019 Stall: adv = !out_valid | out_ready; in_ready = adv; all stages SHALL hold when adv=0.
REQ-020 Bubbles SHALL propagate as stage-valid=0 and SHALL NOT be compressed.
REQ-021 out_p and out_approx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 in_approx SHALL be sampled per transaction; mixed modes back-to-back SHALL be legal.
REQ-023 A handshake on both in and out in the same cycle SHALL accept the new input and retire the old result.

Reset
REQ-024 While rst=1: all stage valids, out_valid, out_p, out_approx and the statistics SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight transactions; after release in_ready SHALL be 1.

Configuration
REQ-026 Macro APPROX_MULT_ERRSTAT_EN: when defined, the block SHALL add ports stat_clr (in, 1), stat_count (out, 32) and stat_err (out, 48).
REQ-027 With the macro defined, S2 SHALL also carry the exact product; on each retired approximate result, stat_count SHALL increment by 1 and stat_err SHALL add (exact - approx).
REQ-028 Both statistics SHALL saturate at all-ones; stat_clr SHALL zero them synchronously; a retire coincident with stat_clr SHALL be lost.
REQ-029 Without the macro, the statistics ports and logic SHALL be absent and the datapath SHALL be unchanged.

Structure
REQ-030 Package approx_mult_pkg SHALL hold: LAT=3, TILE=4, the legal WIDTH list and the statistics widths (32, 48).
REQ-031 A single sub-module approx_mult_tile4 SHALL implement one 4x4 tile with a 16-bit partial-product mask input; the top SHALL instantiate (WIDTH/4)^2 tiles.

Verification
REQ-032 WIDTH=8, TRUNC=4: a=255, b=255, approx=1 -> out_p=64976 after 3 cycles; approx=0 -> 65025.
REQ-033 WIDTH=8, TRUNC=4, approx=1: a=15,b=15 -> 176; a=1,b=255 -> 240; a=1,b=1 -> 0.
REQ-034 Hold out_ready=0 for 5 cycles while streaming 4 inputs -> in_ready drops once out_valid=1; out_p held stable; no loss or duplication; order preserved.
REQ-035 Assert rst with 3 transactions in flight -> out_valid=0 immediately; none emerge after release.
REQ-036 With APPROX_MULT_ERRSTAT_EN, WIDTH=8, TRUNC=4: two approx 255*255 plus one exact -> stat_count=2, stat_err=98; stat_clr -> both 0.
REQ-037 Random mixed-mode stream for WIDTH in {4,8,16}, TRUNC in {0,WIDTH}, random out_ready -> every result matches the reference model.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants for the approximate multiplier pipeline: depth, tile size,
// supported operand widths and error-statistics counter widths.
package approx_mult_pkg;

  localparam int LAT        = 3;
  localparam int TILE       = 4;
  localparam int N_WIDTHS   = 4;
  localparam int LEGAL_WIDTH [N_WIDTHS] = '{4, 8, 12, 16};
  localparam int STAT_CNT_W = 32;
  localparam int STAT_ERR_W = 48;

  function automatic bit is_legal_width(input int w);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < N_WIDTHS; k++)
      if (LEGAL_WIDTH[k] == w) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/approx_mult_if.sv
// Valid/ready operand and result channels of the approximate multiplier.
interface approx_mult_if
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_approx;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               out_approx;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_p, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_p, out_approx
  );

endinterface

// File: rtl/approx_mult_tile4.sv
// One 4x4 unsigned tile: sums the partial products a[i]&b[j] whose mask bit
// (index i*4+j) is set, each weighted 2^(i+j) within the tile.
module approx_mult_tile4
  import approx_mult_pkg::*;
(
  input  logic [TILE-1:0]      a,
  input  logic [TILE-1:0]      b,
  input  logic [TILE*TILE-1:0] mask,
  output logic [2*TILE-1:0]    p
);

  localparam int PW = 2 * TILE;

  always_comb begin
    p = '0;
    for (int i = 0; i < TILE; i++)
      for (int j = 0; j < TILE; j++)
        if (mask[i*TILE+j] && a[i] && b[j])
          p = p + (PW'(1) << (i + j));
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined unsigned multiplier with selectable column truncation.
// Optional error statistics are built when APPROX_MULT_ERRSTAT_EN is defined.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  approx_mult_if.slave          bus
`ifdef APPROX_MULT_ERRSTAT_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_CNT_W-1:0] stat_count,
  output logic [STAT_ERR_W-1:0] stat_err
`endif
);

  localparam int NT    = WIDTH / TILE;
  localparam int NTILE = NT * NT;
  localparam int PW    = 2 * WIDTH;

  logic                 adv;
  logic                 vld_p0, vld_p1, vld_p2;
  logic [WIDTH-1:0]     a_p0, b_p0;
  logic                 approx_p0, approx_p1, approx_p2;
  logic [TILE*TILE-1:0] mask_p0   [NTILE];
  logic [2*TILE-1:0]    tile_comb [NTILE];
  logic [2*TILE-1:0]    tile_p1   [NTILE];
  logic [PW-1:0]        sum_p1;
  logic [PW-1:0]        out_p_p2;

  // A full output register blocks everything behind it; bubbles are kept.
  assign adv            = !vld_p2 || bus.out_ready;
  assign bus.in_ready   = adv;
  assign bus.out_valid  = vld_p2;
  assign bus.out_p      = out_p_p2;
  assign bus.out_approx = approx_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      out_p_p2 <= '0;
      approx_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0    <= bus.in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_p_p2  <= sum_p1;
      approx_p2 <= approx_p1;
    end
  end

  // ---- S1: operand and mode capture ----
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p0      <= bus.in_a;
      b_p0      <= bus.in_b;
      approx_p0 <= bus.in_approx;
    end
  end

  // Column of bit pair (i,j) in tile (ti,tj) is 4*ti+i + 4*tj+j.
  always_comb begin
    for (int t = 0; t < NTILE; t++) begin
      mask_p0[t] = '0;
      for (int i = 0; i < TILE; i++)
        for (int j = 0; j < TILE; j++)
          mask_p0[t][i*TILE+j] = !approx_p0 ||
            ((TILE*(t/NT) + i + TILE*(t%NT) + j) >= TRUNC);
    end
  end

  for (genvar t = 0; t < NTILE; t++) begin : g_tile
    approx_mult_tile4 u_tile (
      .a    (a_p0[TILE*(t/NT) +: TILE]),
      .b    (b_p0[TILE*(t%NT) +: TILE]),
      .mask (mask_p0[t]),
      .p    (tile_comb[t])
    );
  end

  // ---- S2: registered tile products ----
  always_ff @(posedge clk) begin
    if (adv) begin
      tile_p1   <= tile_comb;
      approx_p1 <= approx_p0;
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int t = 0; t < NTILE; t++)
      sum_p1 = sum_p1 + (PW'(tile_p1[t]) << (TILE * (t/NT + t%NT)));
  end

  // ---- S3: tile sum registered as out_p (reset block above) ----

`ifdef APPROX_MULT_ERRSTAT_EN
  logic [PW-1:0] exact_p1, exact_p2;
  logic          retire_approx;

  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [STAT_ERR_W-1:0] sat_add(input logic [STAT_ERR_W-1:0] acc,
                                                    input logic [STAT_ERR_W-1:0] d);
    logic [STAT_ERR_W:0] s;
    s = {1'b0, acc} + {1'b0, d};
    return s[STAT_ERR_W] ? '1 : s[STAT_ERR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (adv) begin
      exact_p1 <= PW'(a_p0) * PW'(b_p0);
      exact_p2 <= exact_p1;
    end
  end

  assign retire_approx = vld_p2 && bus.out_ready && approx_p2;

  // Truncation only drops terms, so exact - approx is never negative.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count <= '0;
      stat_err   <= '0;
    end else if (stat_clr) begin
      stat_count <= '0;
      stat_err   <= '0;
    end else if (retire_approx) begin
      stat_count <= sat_inc(stat_count);
      stat_err   <= sat_add(stat_err, STAT_ERR_W'(exact_p2 - out_p_p2));
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe (WIDTH=8, TRUNC=4); statistics checks are
// included when APPROX_MULT_ERRSTAT_EN is defined.
module tb_approx_mult_pipe;

  localparam int W = 8;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  approx_mult_if #(.WIDTH(W)) bus ();

`ifdef APPROX_MULT_ERRSTAT_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_count;
  logic [47:0] stat_err;
`endif

  approx_mult_pipe #(.WIDTH(W), .TRUNC(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef APPROX_MULT_ERRSTAT_EN
    ,
    .stat_clr   (stat_clr),
    .stat_count (stat_count),
    .stat_err   (stat_err)
`endif
  );

  always #5 clk = ~clk;

  logic [2*W:0]   sb [$];
  logic           held_v  = 1'b0;
  logic [2*W-1:0] held_p;
  logic           held_ap;

  logic [W-1:0]   da [9] = '{8'd255, 8'd15, 8'd1,   8'd1, 8'd15, 8'd200, 8'd3, 8'd16, 8'd12};
  logic [W-1:0]   db [9] = '{8'd255, 8'd15, 8'd255, 8'd1, 8'd15, 8'd100, 8'd5, 8'd16, 8'd12};
  logic           dm [9] = '{1'b0,   1'b1,  1'b1,   1'b1, 1'b0,  1'b0,   1'b1, 1'b1,  1'b1};
  logic [2*W-1:0] de [9] = '{16'd65025, 16'd176, 16'd240, 16'd0, 16'd225,
                             16'd20000, 16'd0, 16'd256, 16'd144};

  logic [W-1:0]   sa [4] = '{8'd7, 8'd7, 8'd255, 8'd128};
  logic [W-1:0]   sbv[4] = '{8'd9, 8'd9, 8'd1,   8'd128};
  logic           sm [4] = '{1'b1, 1'b0, 1'b1,   1'b1};
  logic [2*W-1:0] se [4] = '{16'd48, 16'd63, 16'd240, 16'd16384};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bit-level reference: keep partial product (i,j) unless approximate and i+j < T.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ap);
    logic [2*W-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (!ap || (i + j) >= T))
          s = s + ((2*W)'(1) << (i + j));
    return s;
  endfunction

  // One cycle: drive at the falling edge, score anything that retires or holds.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ap, input logic ordy, input logic [2*W-1:0] exp,
                       output logic acc);
    logic [2*W:0] e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = ap;
    bus.out_ready = ordy;
    #1;
    if (held_v) begin
      chk("hold_valid",  bus.out_valid,  1);
      chk("hold_p",      bus.out_p,      held_p);
      chk("hold_approx", bus.out_approx, held_ap);
    end
    held_v = 1'b0;
    if (bus.out_valid) begin
      if (ordy) begin
        chk("out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_p",      bus.out_p,      e[2*W-1:0]);
          chk("out_approx", bus.out_approx, e[2*W]);
        end
      end else begin
        held_v  = 1'b1;
        held_p  = bus.out_p;
        held_ap = bus.out_approx;
      end
    end
    acc = v && bus.in_ready;
    if (acc) sb.push_back({ap, exp});
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                      input logic [2*W-1:0] exp, input logic rnd_ready);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      drive(1'b1, a, b, ap, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, exp, acc);
      n++;
    end
    if (!acc) chk("send_timeout", n, 0);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 20) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic         acc;
    int           idx;
    int           quiet;
    logic [W-1:0] ra, rb;
    logic         rm;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_p",      bus.out_p,      0);
    chk("rst_out_approx", bus.out_approx, 0);
    chk("rst_in_ready",   bus.in_ready,   1);
`ifdef APPROX_MULT_ERRSTAT_EN
    chk("rst_stat_count", stat_count, 0);
    chk("rst_stat_err",   stat_err,   0);
`endif
    rst = 1'b0;

    // Latency: one approximate 255*255, visible after the third rising edge.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd255;
    bus.in_b      = 8'd255;
    bus.in_approx = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("lat_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("lat_edge1_valid", bus.out_valid, 0);
    @(negedge clk);
    #1 chk("lat_edge2_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_edge3_valid",  bus.out_valid,  1);
    chk("lat_edge3_p",      bus.out_p,      64976);
    chk("lat_edge3_approx", bus.out_approx, 1);
    drain();

    // Back-to-back mixed-mode directed vectors.
    for (int k = 0; k < 9; k++) send(da[k], db[k], dm[k], de[k], 1'b0);
    drain();

    // Downstream stalled for five cycles while four inputs are offered.
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(idx < 4, sa[idx%4], sbv[idx%4], sm[idx%4], 1'b0, se[idx%4], acc);
      if (acc) idx++;
    end
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_accepted", idx, 3);
    while (idx < 4) begin
      send(sa[idx], sbv[idx], sm[idx], se[idx], 1'b0);
      idx++;
    end
    drain();

    // Reset with three transactions in flight.
    for (int k = 0; k < 3; k++) send(da[k], db[k], dm[k], de[k], 1'b0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_p",     bus.out_p,     0);
    sb.delete();
    held_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1 chk("postrst_in_ready", bus.in_ready, 1);
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 if (bus.out_valid) quiet++;
    end
    chk("postrst_no_output", quiet, 0);

`ifdef APPROX_MULT_ERRSTAT_EN
    chk("stat_count_after_rst", stat_count, 0);
    send(8'd255, 8'd255, 1'b1, 16'd64976, 1'b0);
    send(8'd255, 8'd255, 1'b1, 16'd64976, 1'b0);
    send(8'd255, 8'd255, 1'b0, 16'd65025, 1'b0);
    drain();
    chk("stat_count", stat_count, 2);
    chk("stat_err",   stat_err,   98);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("stat_clr_count", stat_count, 0);
    chk("stat_clr_err",   stat_err,   0);
`endif

    // Mixed-mode stream with random downstream back-pressure.
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      send(ra, rb, rm, ref_mul(ra, rb, rm), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
